// File: rtl/pmem_burst_if.sv
// Cache-side line port and memory-side burst port of the pmem burst adaptor.
// slave is the adaptor's view; master is the view of the cache plus memory around it.
interface pmem_burst_if #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
);
  logic [31:0]        pmem_address;
  logic               pmem_read;
  logic               pmem_write;
  logic [s_line-1:0]  pmem_wdata;
  logic [s_line-1:0]  pmem_rdata;
  logic               pmem_resp;
  logic [31:0]        burst_address;
  logic               burst_read;
  logic               burst_write;
  logic [s_burst-1:0] burst_wdata;
  logic [s_burst-1:0] burst_rdata;
  logic               burst_resp;

  modport slave (
    input  pmem_address, pmem_read, pmem_write, pmem_wdata, burst_rdata, burst_resp,
    output pmem_rdata, pmem_resp, burst_address, burst_read, burst_write, burst_wdata
  );

  modport master (
    output pmem_address, pmem_read, pmem_write, pmem_wdata, burst_rdata, burst_resp,
    input  pmem_rdata, pmem_resp, burst_address, burst_read, burst_write, burst_wdata
  );
endinterface

// File: rtl/pmem_burst_adaptor.sv
// Converts 256-bit cache line reads/writebacks into 4-beat 64-bit memory bursts
// and returns a one-cycle pmem_resp when the line transfer is complete.
module pmem_burst_adaptor #(
  parameter int s_line   = 256,
  parameter int s_burst  = 64,
  parameter int s_offset = 5
) (
  input logic            clk,
  input logic            rst,
  pmem_burst_if.slave    bus
);
  localparam int s_beats = s_line / s_burst;
  localparam int s_cnt   = $clog2(s_beats);
  localparam int s_sh    = $clog2(s_burst);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [31:0]      addr_mask = ~((32'd1 << s_offset) - 32'd1);
  localparam logic [s_cnt-1:0] cnt_last  = s_cnt'(s_beats - 1);

  logic [1:0]        state_q, state_d;
  logic [s_cnt-1:0]  cnt_q, cnt_d;
  logic [s_line-1:0] line_q, line_d;
  logic [s_line-1:0] rdata_q, rdata_d;
  logic [31:0]       addr_q, addr_d;
  logic              resp_q, resp_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;

  logic [s_cnt+s_sh-1:0] beat_base;
  logic                  last_beat;

  assign beat_base = {cnt_q, {s_sh{1'b0}}};
  assign last_beat = (cnt_q == cnt_last);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    resp_d  = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // Writeback has priority; a concurrent read is picked up after DONE if still held.
        if (bus.pmem_write) begin
          state_d = WR;
          line_d  = bus.pmem_wdata;
          addr_d  = bus.pmem_address & addr_mask;
          cnt_d   = {s_cnt{1'b0}};
          wr_d    = 1'b1;
        end else if (bus.pmem_read) begin
          state_d = RD;
          addr_d  = bus.pmem_address & addr_mask;
          cnt_d   = {s_cnt{1'b0}};
          rd_d    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        rd_d = 1'b1;
        if (bus.burst_resp) begin
          line_d[beat_base +: s_burst] = bus.burst_rdata;
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            state_d = DONE;
            rd_d    = 1'b0;
            resp_d  = 1'b1;
            rdata_d = line_d;
          end else begin
            state_d = RD;
          end
        end else begin
          state_d = RD;
        end
      end
      WR: begin
        wr_d = 1'b1;
        if (bus.burst_resp) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            state_d = DONE;
            wr_d    = 1'b0;
            resp_d  = 1'b1;
          end else begin
            state_d = WR;
          end
        end else begin
          state_d = WR;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {s_cnt{1'b0}};
      line_q  <= {s_line{1'b0}};
      rdata_q <= {s_line{1'b0}};
      addr_q  <= 32'd0;
      resp_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      resp_q  <= resp_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  assign bus.pmem_rdata    = rdata_q;
  assign bus.pmem_resp     = resp_q;
  assign bus.burst_address = addr_q;
  assign bus.burst_read    = rd_q;
  assign bus.burst_write   = wr_q;
  // Gated so the write beat bus is quiet outside WR, including while in reset.
  assign bus.burst_wdata   = (state_q == WR) ? line_q[beat_base +: s_burst] : {s_burst{1'b0}};
endmodule

// File: tb/tb_pmem_burst_adaptor.sv
// Scoreboard bench for pmem_burst_adaptor: stimulus queues expected line transactions,
// a memory model/monitor process answers bursts and checks every beat and response.
module tb_pmem_burst_adaptor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pmem_burst_if #(.s_line(256), .s_burst(64)) bus();

  pmem_burst_adaptor #(.s_line(256), .s_burst(64), .s_offset(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [255:0] wdata;
  } txn_t;

  txn_t        sb[$];
  logic [63:0] beats[$];
  bit          pat_q[$];
  logic [63:0] dat_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int resp_cnt = 0;
  int cyc = 0;
  int last_beat_cyc = 0;
  int nbeats = 0;
  bit started = 1'b0;
  logic [255:0] last_line = '0;

  bit           m_strobe;
  bit           m_r;
  logic [63:0]  m_d;
  logic [255:0] m_line;
  logic [255:0] m_w;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model and monitor: answers bursts, records beats, checks responses.
  initial begin
    bus.burst_resp  = 1'b0;
    bus.burst_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (rst) begin
        beats.delete();
        nbeats = 0;
        started = 1'b0;
        bus.burst_resp = 1'b0;
      end else begin
        m_strobe = bus.burst_read | bus.burst_write;
        if (bus.pmem_resp === 1'b1) begin
          resp_cnt++;
          if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_resp: got pmem_resp=1 expected no response");
          end else begin
            check("resp_latency", 256'(cyc), 256'(last_beat_cyc + 1));
            check("beat_count", 256'(nbeats), 256'd4);
            check("strobes_low_in_done", {254'd0, bus.burst_read, bus.burst_write}, 256'd0);
            if (sb[0].wr) begin
              check("wb_rdata_kept", bus.pmem_rdata, last_line);
            end else begin
              m_line = '0;
              for (int i = 0; i < 4; i++) begin
                if (i < beats.size()) m_line[i*64 +: 64] = beats[i];
              end
              last_line = m_line;
              check("rd_line", bus.pmem_rdata, m_line);
            end
            void'(sb.pop_front());
            beats.delete();
            nbeats = 0;
            started = 1'b0;
          end
        end
        if (m_strobe) begin
          if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_burst: got rd=%b wr=%b expected idle", bus.burst_read, bus.burst_write);
          end else begin
            if (!started) begin
              check("burst_kind", {255'd0, bus.burst_write}, {255'd0, sb[0].wr});
              check("burst_address", {224'd0, bus.burst_address}, {224'd0, sb[0].addr[31:5], 5'b00000});
              started = 1'b1;
            end
            if (nbeats >= 4) begin
              n_cmp++; n_bad++;
              $display("FAIL extra_beat: got strobe after %0d beats expected 4 max", nbeats);
            end
          end
        end
        if (m_strobe && pat_q.size() > 0) m_r = pat_q.pop_front();
        else m_r = ($urandom_range(0, 2) != 0);
        m_d = {$urandom, $urandom};
        if (bus.burst_read && m_r && dat_q.size() > 0) m_d = dat_q.pop_front();
        bus.burst_resp  = m_r;
        bus.burst_rdata = m_d;
        if (m_strobe && m_r && sb.size() > 0 && nbeats < 4) begin
          if (bus.burst_write) begin
            m_w = sb[0].wdata;
            check("wr_beat", {192'd0, bus.burst_wdata}, {192'd0, m_w[nbeats*64 +: 64]});
          end else begin
            beats.push_back(m_d);
          end
          nbeats++;
          last_beat_cyc = cyc;
        end
      end
    end
  end

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic wait_resp(input int target, input string name);
    int n;
    n = 0;
    while (resp_cnt < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (resp_cnt < target) begin
      n_bad++;
      $display("FAIL %s_timeout: got no pmem_resp within %0d cycles expected one", name, n);
      sb.delete();
    end
  endtask

  // kind: 0 read, 1 write, 2 read and write together. Called at a negedge.
  task automatic do_req(input int kind, input logic [31:0] a, input logic [255:0] w);
    txn_t t;
    int base;
    base = resp_cnt;
    t.addr  = a;
    t.wdata = w;
    bus.pmem_address = a;
    bus.pmem_wdata   = w;
    if (kind == 0) begin
      t.wr = 1'b0;
      sb.push_back(t);
      bus.pmem_read = 1'b1;
    end else begin
      t.wr = 1'b1;
      sb.push_back(t);
      bus.pmem_write = 1'b1;
      bus.pmem_read  = (kind == 2);
    end
    wait_resp(base + 1, "req");
    bus.pmem_write = 1'b0;
    if (kind == 2) begin
      t.wr = 1'b0;
      sb.push_back(t);
      wait_resp(base + 2, "held_read");
    end
    bus.pmem_read = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_pmem_rdata", bus.pmem_rdata, 256'd0);
    check("rst_pmem_resp", {255'd0, bus.pmem_resp}, 256'd0);
    check("rst_burst_address", {224'd0, bus.burst_address}, 256'd0);
    check("rst_burst_read", {255'd0, bus.burst_read}, 256'd0);
    check("rst_burst_write", {255'd0, bus.burst_write}, 256'd0);
    check("rst_burst_wdata", {192'd0, bus.burst_wdata}, 256'd0);
    sb.delete();
    pat_q.delete();
    dat_q.delete();
    last_line = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic expect_quiet(input string name, input int ncyc);
    int hits;
    hits = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (bus.pmem_resp !== 1'b0) hits++;
    end
    check(name, 256'(hits), 256'd0);
  endtask

  task automatic load_beats(input logic [63:0] b0, input logic [63:0] b1,
                            input logic [63:0] b2, input logic [63:0] b3);
    dat_q.push_back(b0); dat_q.push_back(b1); dat_q.push_back(b2); dat_q.push_back(b3);
  endtask

  initial begin
    logic [255:0] dline;
    int waited;
    rst = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_wdata   = '0;

    #2;
    apply_reset();
    expect_quiet("idle_no_resp", 4);

    // Consecutive-beat read of the example line.
    load_beats(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
    for (int i = 0; i < 4; i++) pat_q.push_back(1'b1);
    do_req(0, 32'h1234_567F, rand_line());
    check("rd_example_line", bus.pmem_rdata,
          {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    check("rd_example_addr", {224'd0, bus.burst_address}, {224'd0, 32'h1234_5660});

    // Writeback serialization; read line must be untouched.
    dline = {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
             64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0};
    for (int i = 0; i < 4; i++) pat_q.push_back(1'b1);
    @(negedge clk);
    do_req(1, 32'hABCD_0020, dline);
    check("wb_keeps_example_line", bus.pmem_rdata,
          {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

    // Stalled memory: 1,0,0,1,0,1,1.
    pat_q.push_back(1'b1); pat_q.push_back(1'b0); pat_q.push_back(1'b0); pat_q.push_back(1'b1);
    pat_q.push_back(1'b0); pat_q.push_back(1'b1); pat_q.push_back(1'b1);
    load_beats(64'hA0A0_0000_0000_0001, 64'hA1A1_0000_0000_0002,
               64'hA2A2_0000_0000_0003, 64'hA3A3_0000_0000_0004);
    @(negedge clk);
    do_req(0, 32'h0000_1F3C, rand_line());

    // Simultaneous request: write first, then the held read.
    @(negedge clk);
    do_req(2, 32'h7777_8888, rand_line());

    // Abort a read after two beats.
    @(negedge clk);
    begin
      txn_t t;
      t.wr = 1'b0; t.addr = 32'h0BAD_F00D; t.wdata = '0;
      sb.push_back(t);
      bus.pmem_address = t.addr;
      bus.pmem_read = 1'b1;
    end
    waited = 0;
    while (nbeats < 2 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("abort_reached_two_beats", {255'd0, (nbeats >= 2)}, 256'd1);
    bus.pmem_read = 1'b0;
    #1;
    apply_reset();
    expect_quiet("abort_no_resp", 6);
    for (int i = 0; i < 4; i++) pat_q.push_back(1'b1);
    load_beats(64'hC0C0_C0C0_0000_0000, 64'hC1C1_C1C1_0000_0000,
               64'hC2C2_C2C2_0000_0000, 64'hC3C3_C3C3_0000_0000);
    do_req(0, 32'h4000_0040, rand_line());
    check("post_abort_line", bus.pmem_rdata,
          {64'hC3C3_C3C3_0000_0000, 64'hC2C2_C2C2_0000_0000,
           64'hC1C1_C1C1_0000_0000, 64'hC0C0_C0C0_0000_0000});

    // Randomized traffic with random memory stalls.
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      do_req(int'($urandom_range(0, 2)), $urandom, rand_line());
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 256'(sb.size()), 256'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
